// File: rtl/pipe_chain_pkg.sv
// rtl/pipe_chain_pkg.sv - shared width helper and stage index/count types for pipe_chain users
package pipe_chain_pkg;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  localparam int DEF_DEPTH = 4;

  // Templates for hazard logic sized to the default chain depth
  typedef logic [clog2_min1(DEF_DEPTH)-1:0] stage_idx_t;
  typedef logic [$clog2(DEF_DEPTH+1)-1:0]   stage_cnt_t;

endpackage

// File: rtl/pipe_chain_stage.sv
// rtl/pipe_chain_stage.sv - one elastic stage: valid bit plus payload register
// Optional build macro PIPE_CHAIN_DATA_RESET_EN also clears the payload register on reset.
module pipe_chain_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] data_in,
  output logic             valid,
  output logic [WIDTH-1:0] data_out
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // A refill on the same edge as the stage empties wins over the clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
    end else if (load) begin
      r_valid <= 1'b1;
    end else if (clear) begin
      r_valid <= 1'b0;
    end
  end

`ifdef PIPE_CHAIN_DATA_RESET_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data <= '0;
    end else if (load) begin
      r_data <= data_in;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (load) begin
      r_data <= data_in;
    end
  end
`endif

  assign valid    = r_valid;
  assign data_out = r_data;

endmodule

// File: rtl/pipe_chain.sv
// rtl/pipe_chain.sv - elastic DEPTH-stage pipeline with bubble collapsing and partial flush
// Optional build macro PIPE_CHAIN_DATA_RESET_EN (handled in pipe_chain_stage).
module pipe_chain
  import pipe_chain_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int IDXW  = clog2_min1(DEPTH),
  parameter int CNTW  = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  input  logic [IDXW-1:0]  flush_from,
  output logic [DEPTH-1:0] stage_valid,
  output logic [CNTW-1:0]  count
);

  logic [DEPTH-1:0] w_v;
  logic [DEPTH-1:0] w_vm;
  logic [DEPTH-1:0] w_fmask;
  logic [DEPTH-1:0] w_adv;
  logic [DEPTH-1:0] w_load;
  logic [DEPTH-1:0] w_clear;
  logic [31:0]      w_ff;
  logic [WIDTH-1:0] w_data [DEPTH];

  always_comb begin
    w_ff = 32'(flush_from);
    if (w_ff > 32'(DEPTH-1)) w_ff = 32'(DEPTH-1);
    for (int i = 0; i < DEPTH; i++) begin
      w_fmask[i] = flush & (32'(i) <= w_ff);
    end
  end

  // Flushed stages look empty to the advance logic, cancelling their moves
  assign w_vm = w_v & ~w_fmask;

  // Stage i is blocked only when every older stage is occupied and the output stalls
  always_comb begin
    logic w_full;
    w_adv = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_full = 1'b1;
      for (int j = i + 1; j < DEPTH; j++) begin
        w_full = w_full & w_vm[j];
      end
      w_adv[i] = w_vm[i] & ~(w_full & ~out_ready);
    end
  end

  assign in_ready = (~w_vm[0] | w_adv[0]) & ~flush;

  always_comb begin
    w_load    = w_adv << 1;
    w_load[0] = in_valid & in_ready;
  end

  assign w_clear = w_adv | w_fmask;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic [WIDTH-1:0] w_din;
    if (g == 0) begin : g_head
      assign w_din = in_data;
    end else begin : g_body
      assign w_din = w_data[g-1];
    end

    pipe_chain_stage #(.WIDTH(WIDTH)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .load     (w_load[g]),
      .clear    (w_clear[g]),
      .data_in  (w_din),
      .valid    (w_v[g]),
      .data_out (w_data[g])
    );
  end

  assign out_valid   = w_vm[DEPTH-1];
  assign out_data    = w_data[DEPTH-1];
  assign stage_valid = w_v;

  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count = count + CNTW'(w_v[i]);
    end
  end

endmodule
